// File: rtl/data_serializer.sv
// Frame serializer: captures STAGE parallel words on load and emits them one per
// handshake with start/done framing. Define DATA_SERIALIZER_REVERSE_EN to send the last word first.
module data_serializer #(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DWIDTH-1:0] data_d [0:STAGE-1],
  input  logic              out_ready,
  output logic              start,
  output logic [DWIDTH-1:0] data,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int IW = (STAGE > 2) ? $clog2(STAGE) : 1;
  localparam logic [IW-1:0] LAST = IW'(STAGE - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     sel;
  logic [DWIDTH-1:0] frame_q [0:STAGE-1];
  logic              capture;
  logic              idx_inc;

  // The index always counts up; reverse order is a mapping onto the buffer.
`ifdef DATA_SERIALIZER_REVERSE_EN
  assign sel = LAST - idx_q;
`else
  assign sel = idx_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < STAGE; i++) frame_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        frame_q <= data_d;
        idx_q   <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    data      = '0;
    capture   = 1'b0;
    idx_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = START;
        end
      end
      START: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        data      = frame_q[sel];
        // Last transfer leaves the index parked at LAST instead of wrapping.
        if (out_ready) begin
          if (idx_q == LAST) state_d = DONE;
          else               idx_inc = 1'b1;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
